// File: rtl/epd_param_pkg.sv
// Shared definitions for the parametrised Ethernet packet detector:
// FSM state encoding, framing byte values, header field lengths and the DST filter rule.
package epd_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_DST     = 3'd2,
    ST_SRC     = 3'd3,
    ST_TL      = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_DROP    = 3'd6
  } state_t;

  localparam logic [7:0]  PRE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE   = 8'hD5;
  localparam logic [2:0]  DST_LEN    = 3'd6;
  localparam logic [2:0]  SRC_LEN    = 3'd6;
  localparam logic [2:0]  TL_LEN     = 3'd2;
  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  // Promiscuous mode accepts everything; otherwise only our own address or broadcast.
  function automatic logic addr_match(input logic [47:0] dst,
                                      input logic [47:0] mine,
                                      input logic        filt);
    return (!filt) || (dst == mine) || (dst == BCAST_ADDR);
  endfunction

endpackage

// File: rtl/epd_param_sat_counter.sv
// Event counter for the packet detector: wraps modulo 2^W, or sticks at all-ones when SAT=1.
module epd_sat_counter #(
  parameter int W   = 4,
  parameter bit SAT = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_hold;

  assign w_hold = SAT && (&r_count);
  assign count  = r_count;

  // Count register; a pending increment is lost if reset is low on that edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && !w_hold) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/epd_param.sv
// Ethernet RX packet detector: preamble/SFD lock, DST filtering, header tracking,
// frame length measurement and accepted/dropped frame counters for the host registers.
module epd_param
  import epd_param_pkg::*;
#(
  parameter int PRE_MIN = 7,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11,
  parameter int CNT_W   = 4,
  parameter bit SAT     = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       data,
  input  logic             control,
  input  logic             filter_en,
  input  logic [47:0]      my_addr,
  output logic             preamble_valid,
  output logic             dst_addr_valid,
  output logic             src_addr_valid,
  output logic             type_length_valid,
  output logic             packet_size_valid,
  output logic [CNT_W-1:0] valid_packet_counter,
  output logic [CNT_W-1:0] drop_counter,
  output logic [LEN_W-1:0] frame_len
);

  localparam logic [7:0]       PRE_MIN_L = 8'(PRE_MIN);
  localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t           r_state, w_state;
  logic [7:0]       r_pre_cnt, w_pre_cnt;
  logic [2:0]       r_byte_cnt, w_byte_cnt;
  logic [39:0]      r_dst, w_dst;
  logic [LEN_W-1:0] r_frame_len, w_frame_len;
  logic             r_pre_v, w_pre_v;
  logic             r_dst_v, w_dst_v;
  logic             r_src_v, w_src_v;
  logic             r_tl_v, w_tl_v;
  logic             r_size_v, w_size_v;
  logic             w_inc_valid, w_inc_drop;
  logic [LEN_W-1:0] w_len_inc;
  logic [7:0]       w_pre_inc;
  logic [47:0]      w_dst_full;
  logic             w_match;

  assign w_len_inc  = (&r_frame_len) ? r_frame_len : r_frame_len + LEN_W'(1);
  assign w_pre_inc  = (&r_pre_cnt) ? r_pre_cnt : r_pre_cnt + 8'd1;
  // Only the first five DST bytes are stored; the sixth is taken straight off the bus.
  assign w_dst_full = {r_dst, data};
  assign w_match    = addr_match(w_dst_full, my_addr, filter_en);

  // Next-state and next-value logic for the whole frame walker.
  always_comb begin
    w_state     = r_state;
    w_pre_cnt   = r_pre_cnt;
    w_byte_cnt  = r_byte_cnt;
    w_dst       = r_dst;
    w_frame_len = r_frame_len;
    w_pre_v     = r_pre_v;
    w_dst_v     = r_dst_v;
    w_src_v     = r_src_v;
    w_tl_v      = r_tl_v;
    w_size_v    = 1'b0;
    w_inc_valid = 1'b0;
    w_inc_drop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (control && (data == PRE_BYTE)) begin
          w_state   = ST_PRE;
          w_pre_cnt = 8'd1;
          w_pre_v   = 1'b0;
          w_dst_v   = 1'b0;
          w_src_v   = 1'b0;
          w_tl_v    = 1'b0;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (!control) begin
          w_state = ST_IDLE;
        end else if (data == PRE_BYTE) begin
          w_pre_cnt = w_pre_inc;
        end else if ((data == SFD_BYTE) && (r_pre_cnt >= PRE_MIN_L)) begin
          w_state     = ST_DST;
          w_pre_v     = 1'b1;
          w_frame_len = '0;
          w_byte_cnt  = 3'd0;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_DST: begin
        if (!control) begin
          w_state    = ST_IDLE;
          w_inc_drop = 1'b1;
        end else begin
          w_frame_len = w_len_inc;
          w_dst       = {r_dst[31:0], data};
          if (r_byte_cnt == (DST_LEN - 3'd1)) begin
            w_byte_cnt = 3'd0;
            if (w_match) begin
              w_dst_v = 1'b1;
              w_state = ST_SRC;
            end else begin
              w_state = ST_DROP;
            end
          end else begin
            w_byte_cnt = r_byte_cnt + 3'd1;
          end
        end
      end
      ST_SRC: begin
        if (!control) begin
          w_state    = ST_IDLE;
          w_inc_drop = 1'b1;
        end else begin
          w_frame_len = w_len_inc;
          if (r_byte_cnt == (SRC_LEN - 3'd1)) begin
            w_byte_cnt = 3'd0;
            w_src_v    = 1'b1;
            w_state    = ST_TL;
          end else begin
            w_byte_cnt = r_byte_cnt + 3'd1;
          end
        end
      end
      ST_TL: begin
        if (!control) begin
          w_state    = ST_IDLE;
          w_inc_drop = 1'b1;
        end else begin
          w_frame_len = w_len_inc;
          if (r_byte_cnt == (TL_LEN - 3'd1)) begin
            w_byte_cnt = 3'd0;
            w_tl_v     = 1'b1;
            w_state    = ST_PAYLOAD;
          end else begin
            w_byte_cnt = r_byte_cnt + 3'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!control) begin
          w_state = ST_IDLE;
          if ((r_frame_len >= MIN_LEN_L) && (r_frame_len <= MAX_LEN_L)) begin
            w_size_v    = 1'b1;
            w_inc_valid = 1'b1;
          end else begin
            w_inc_drop = 1'b1;
          end
        end else begin
          w_frame_len = w_len_inc;
        end
      end
      ST_DROP: begin
        if (!control) begin
          w_state    = ST_IDLE;
          w_inc_drop = 1'b1;
        end else begin
          w_frame_len = w_len_inc;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Datapath and status flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre_cnt   <= 8'd0;
      r_byte_cnt  <= 3'd0;
      r_dst       <= 40'd0;
      r_frame_len <= '0;
      r_pre_v     <= 1'b0;
      r_dst_v     <= 1'b0;
      r_src_v     <= 1'b0;
      r_tl_v      <= 1'b0;
      r_size_v    <= 1'b0;
    end else begin
      r_pre_cnt   <= w_pre_cnt;
      r_byte_cnt  <= w_byte_cnt;
      r_dst       <= w_dst;
      r_frame_len <= w_frame_len;
      r_pre_v     <= w_pre_v;
      r_dst_v     <= w_dst_v;
      r_src_v     <= w_src_v;
      r_tl_v      <= w_tl_v;
      r_size_v    <= w_size_v;
    end
  end

  epd_sat_counter #(.W(CNT_W), .SAT(SAT)) u_valid_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_inc_valid),
    .count (valid_packet_counter)
  );

  epd_sat_counter #(.W(CNT_W), .SAT(SAT)) u_drop_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_inc_drop),
    .count (drop_counter)
  );

  assign preamble_valid    = r_pre_v;
  assign dst_addr_valid    = r_dst_v;
  assign src_addr_valid    = r_src_v;
  assign type_length_valid = r_tl_v;
  assign packet_size_valid = r_size_v;
  assign frame_len         = r_frame_len;

endmodule

// File: tb/tb_epd_param.sv
// Self-checking bench for epd_param: a wrapping and a saturating instance share the
// same byte stream and are checked against a frame-level reference model.
module tb_epd_param;

  localparam int PRE_MIN = 7;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int LEN_W   = 11;
  localparam int CNT_W   = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       data = 8'h00;
  logic             control = 1'b0;
  logic             filter_en = 1'b0;
  logic [47:0]      my_addr = 48'h0;

  logic             preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid, packet_size_valid;
  logic [CNT_W-1:0] valid_packet_counter, drop_counter;
  logic [LEN_W-1:0] frame_len;
  logic             s_pre_v, s_dst_v, s_src_v, s_tl_v, s_size_v;
  logic [CNT_W-1:0] s_valid_cnt, s_drop_cnt;
  logic [LEN_W-1:0] s_frame_len;

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];
  int         e_valid, e_drop, e_len;
  logic [3:0] e_flags;
  logic       e_pulse;

  epd_param #(.PRE_MIN(PRE_MIN), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
              .CNT_W(CNT_W), .SAT(1'b0)) dut (
    .clock(clock), .reset(reset), .data(data), .control(control),
    .filter_en(filter_en), .my_addr(my_addr),
    .preamble_valid(preamble_valid), .dst_addr_valid(dst_addr_valid),
    .src_addr_valid(src_addr_valid), .type_length_valid(type_length_valid),
    .packet_size_valid(packet_size_valid), .valid_packet_counter(valid_packet_counter),
    .drop_counter(drop_counter), .frame_len(frame_len)
  );

  epd_param #(.PRE_MIN(PRE_MIN), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
              .CNT_W(CNT_W), .SAT(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .data(data), .control(control),
    .filter_en(filter_en), .my_addr(my_addr),
    .preamble_valid(s_pre_v), .dst_addr_valid(s_dst_v),
    .src_addr_valid(s_src_v), .type_length_valid(s_tl_v),
    .packet_size_valid(s_size_v), .valid_packet_counter(s_valid_cnt),
    .drop_counter(s_drop_cnt), .frame_len(s_frame_len)
  );

  always #5 clock = ~clock;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [CNT_W-1:0] cnt_wrap(input int n);
    return CNT_W'(n % (1 << CNT_W));
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat(input int n);
    return (n >= (1 << CNT_W) - 1) ? {CNT_W{1'b1}} : CNT_W'(n);
  endfunction

  function automatic logic [20:0] obs();
    return {packet_size_valid, preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
            valid_packet_counter, drop_counter, s_valid_cnt, s_drop_cnt};
  endfunction

  function automatic logic [20:0] expv();
    return {e_pulse, e_flags, cnt_wrap(e_valid), cnt_wrap(e_drop), cnt_sat(e_valid), cnt_sat(e_drop)};
  endfunction

  task automatic put(input logic c, input logic [7:0] d);
    control = c;
    data    = d;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    e_valid = 0; e_drop = 0; e_len = 0; e_flags = 4'b0000; e_pulse = 1'b0;
  endtask

  // Frame: npre x 55, D5, then the first len bytes of DST/SRC FF..FA/TL 0800/payload.
  task automatic build(input int npre, input logic [47:0] dst, input int len, input logic rnd);
    fq.delete();
    for (int i = 0; i < npre; i++) fq.push_back(8'h55);
    fq.push_back(8'hD5);
    for (int i = 0; i < len; i++) begin
      if (i < 6)        fq.push_back(dst[47 - 8*i -: 8]);
      else if (i < 12)  fq.push_back(8'hFF - 8'(i - 6));
      else if (i == 12) fq.push_back(8'h08);
      else if (i == 13) fq.push_back(8'h00);
      else              fq.push_back(rnd ? 8'($urandom) : 8'h55);
    end
  endtask

  // Reference model: classify the whole frame held in fq and update the expectations.
  task automatic ref_frame(input logic filt, input logic [47:0] mine);
    int          npre, len;
    logic [47:0] d;
    logic        m;
    npre = 0;
    while (npre < fq.size() && fq[npre] == 8'h55) npre++;
    e_pulse = 1'b0;
    e_flags = 4'b0000;
    if (npre < PRE_MIN || npre >= fq.size() || fq[npre] != 8'hD5) return;
    len = fq.size() - npre - 1;
    e_flags[3] = 1'b1;
    d = 48'h0;
    if (len >= 6) for (int i = 0; i < 6; i++) d = {d[39:0], fq[npre + 1 + i]};
    m = (!filt) || (d == mine) || (d == 48'hFFFF_FFFF_FFFF);
    e_flags[2] = (len >= 6) && m;
    e_flags[1] = e_flags[2] && (len >= 12);
    e_flags[0] = e_flags[2] && (len >= 14);
    e_len = (len > (1 << LEN_W) - 1) ? (1 << LEN_W) - 1 : len;
    if (e_flags[0] && len >= MIN_LEN && len <= MAX_LEN) begin
      e_pulse = 1'b1;
      e_valid++;
    end else begin
      e_drop++;
    end
  endtask

  task automatic send_frame();
    foreach (fq[i]) put(1'b1, fq[i]);
    put(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    put(1'b1, 8'h55);
    put(1'b1, 8'hD5);
    checks++;
    if (obs() !== 21'd0 || frame_len !== '0 || s_frame_len !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h len %0d, expected all zero", obs(), frame_len);
    end
    reset = 1'b1;
    e_valid = 0; e_drop = 0; e_len = 0; e_flags = 4'b0000; e_pulse = 1'b0;
    put(1'b0, 8'h00);
  endtask

  task automatic test_basic();
    filter_en = 1'b0;
    build(7, 48'h010203040506, 64, 1'b0);
    ref_frame(filter_en, my_addr);
    send_frame();
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL basic_frame: got %h expected %h", obs(), expv());
    end
    checks++;
    if (frame_len !== 11'd64 || valid_packet_counter !== 4'd1 || packet_size_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_len: got len %0d cnt %0d pulse %b, expected 64 1 1",
               frame_len, valid_packet_counter, packet_size_valid);
    end
    put(1'b0, 8'h00);
    checks++;
    if (packet_size_valid !== 1'b0 || preamble_valid !== 1'b1 || type_length_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse_width: got pulse %b pre %b tl %b, expected 0 1 1",
               packet_size_valid, preamble_valid, type_length_valid);
    end
  endtask

  task automatic test_mid_reset();
    build(7, 48'h010203040506, 64, 1'b0);
    foreach (fq[i]) begin
      if (i == 8 + 14 + 29) begin
        control = 1'b1;
        data    = fq[i];
        reset   = 1'b0;
        #1;
        checks++;
        if (obs() !== 21'd0 || frame_len !== '0) begin
          errors++;
          $display("FAIL mid_reset_async: got %h len %0d, expected zero", obs(), frame_len);
        end
        @(negedge clock);
        reset = 1'b1;
      end else begin
        put(1'b1, fq[i]);
      end
    end
    put(1'b0, 8'h00);
    e_valid = 0; e_drop = 0; e_flags = 4'b0000; e_pulse = 1'b0; e_len = 0;
    checks++;
    if (obs() !== expv() || frame_len !== '0) begin
      errors++;
      $display("FAIL mid_reset_after: got %h len %0d, expected %h len 0", obs(), frame_len, expv());
    end
  endtask

  task automatic test_filter();
    logic [47:0] dsts[3];
    dsts[0] = 48'h010203040506;
    dsts[1] = 48'hFFFF_FFFF_FFFF;
    dsts[2] = 48'h0A0B0C0D0E0F;
    filter_en = 1'b1;
    my_addr   = 48'h010203040506;
    for (int k = 0; k < 3; k++) begin
      build(7, dsts[k], int'($urandom_range(64, 200)), 1'b1);
      ref_frame(filter_en, my_addr);
      send_frame();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL filter_%0d: got %h expected %h", k, obs(), expv());
      end
    end
    checks++;
    if (dst_addr_valid !== 1'b0 || valid_packet_counter !== 4'd2 || drop_counter !== 4'd1) begin
      errors++;
      $display("FAIL filter_totals: got dv %b valid %0d drop %0d, expected 0 2 1",
               dst_addr_valid, valid_packet_counter, drop_counter);
    end
    filter_en = 1'b0;
  endtask

  task automatic test_length();
    int lens[4];
    lens[0] = 54; lens[1] = MAX_LEN + 1; lens[2] = MAX_LEN; lens[3] = MIN_LEN;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      build(7, 48'h0000_0000_0001, lens[k], 1'b1);
      ref_frame(filter_en, my_addr);
      send_frame();
      checks++;
      if (obs() !== expv() || (e_flags[0] && frame_len !== LEN_W'(e_len))) begin
        errors++;
        $display("FAIL length_%0d: got %h len %0d expected %h len %0d",
                 lens[k], obs(), frame_len, expv(), e_len);
      end
      if (k == 1) begin
        checks++;
        if (drop_counter !== 4'd2 || valid_packet_counter !== 4'd0) begin
          errors++;
          $display("FAIL length_drops: got drop %0d valid %0d, expected 2 0",
                   drop_counter, valid_packet_counter);
        end
      end
    end
  endtask

  task automatic test_preamble();
    do_reset();
    build(6, 48'h010203040506, 0, 1'b0);
    ref_frame(filter_en, my_addr);
    send_frame();
    checks++;
    if (obs() !== expv() || preamble_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_preamble: got %h expected %h", obs(), expv());
    end
    build(7, 48'h010203040506, 64, 1'b1);
    ref_frame(filter_en, my_addr);
    send_frame();
    checks++;
    if (obs() !== expv() || valid_packet_counter !== 4'd1) begin
      errors++;
      $display("FAIL preamble_recover: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_truncated();
    int lens[5];
    lens[0] = 0; lens[1] = 3; lens[2] = 10; lens[3] = 13; lens[4] = 14;
    for (int k = 0; k < 5; k++) begin
      build(8, 48'h1122_3344_5566, lens[k], 1'b1);
      ref_frame(filter_en, my_addr);
      send_frame();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL truncated_%0d: got %h expected %h", lens[k], obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    int          npre, len, sel;
    logic [47:0] dst;
    for (int k = 0; k < 24; k++) begin
      filter_en = 1'($urandom_range(0, 1));
      my_addr   = {16'($urandom), 32'($urandom)};
      sel = int'($urandom_range(0, 2));
      dst = (sel == 0) ? my_addr : (sel == 1) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
      sel = int'($urandom_range(0, 9));
      len = (sel < 3) ? int'($urandom_range(0, 20)) :
            (sel < 8) ? int'($urandom_range(55, 90)) : int'($urandom_range(1510, 1525));
      npre = int'($urandom_range(5, 10));
      build(npre, dst, (npre < PRE_MIN) ? 0 : len, 1'b1);
      ref_frame(filter_en, my_addr);
      send_frame();
      checks++;
      if (obs() !== expv() || (e_flags[0] && frame_len !== LEN_W'(e_len))) begin
        errors++;
        $display("FAIL random_%0d: got %h len %0d expected %h len %0d",
                 k, obs(), frame_len, expv(), e_len);
      end
    end
    filter_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 17; k++) begin
      build(7, 48'hA0B0_C0D0_E0F0, 64, 1'b1);
      ref_frame(filter_en, my_addr);
      send_frame();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL back_to_back_%0d: got %h expected %h", k, obs(), expv());
      end
    end
    checks++;
    if (valid_packet_counter !== 4'd1 || s_valid_cnt !== 4'd15 || drop_counter !== 4'd0) begin
      errors++;
      $display("FAIL counter_mode: got wrap %0d sat %0d drop %0d, expected 1 15 0",
               valid_packet_counter, s_valid_cnt, drop_counter);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_reset();
    test_filter();
    test_length();
    test_preamble();
    test_truncated();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
